// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: N_REQ valid/ready write requests in, two registered RF write ports out.
// The slave modport is the arbiter side; the master modport is the requester/RF side.
interface wb_arbiter_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int N_REQ      = 4
);
   logic [N_REQ-1:0]            req_valid;
   logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [N_REQ*DATA_WIDTH-1:0] req_data;
   logic [N_REQ-1:0]            req_ready;
   logic                        we_a;
   logic                        we_b;
   logic [ADDR_WIDTH-1:0]       waddr_a;
   logic [ADDR_WIDTH-1:0]       waddr_b;
   logic [DATA_WIDTH-1:0]       wdata_a;
   logic [DATA_WIDTH-1:0]       wdata_b;
   logic [15:0]                 stall_cnt;

   modport slave (
      input  req_valid, req_addr, req_data,
      output req_ready, we_a, we_b, waddr_a, waddr_b, wdata_a, wdata_b, stall_cnt
   );

   modport master (
      output req_valid, req_addr, req_data,
      input  req_ready, we_a, we_b, waddr_a, waddr_b, wdata_a, wdata_b, stall_cnt
   );
endinterface

// File: rtl/wb_arbiter.sv
// Dual-port register-file writeback arbiter: up to two distinct-address grants per cycle, round-robin.
// Define WB_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest, no rotation pointer).
module wb_arbiter #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int N_REQ      = 4
) (
   input  logic        clk,
   input  logic        rst,
   wb_arbiter_if.slave bus
);
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   typedef logic [IDX_W-1:0] idx_t;

   logic [ADDR_WIDTH-1:0] addr_arr [N_REQ];
   logic [DATA_WIDTH-1:0] data_arr [N_REQ];
   logic [N_REQ-1:0]      ready;
   logic [N_REQ-1:0]      grant;
   logic                  a_hit, b_hit;
   idx_t                  a_idx, b_idx;
   idx_t                  rr_ptr;
   idx_t                  idx;
   logic [IDX_W:0]        pos;

   logic                  we_a_q, we_a_d, we_b_q, we_b_d;
   logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d, waddr_b_q, waddr_b_d;
   logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d, wdata_b_q, wdata_b_d;
   logic [15:0]           stall_cnt_q, stall_cnt_d;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         addr_arr[i] = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         data_arr[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Scan from rr_ptr; address-0 writes are acked without taking a port,
   // and anything matching port A's address waits so B never collides with A.
   always_comb begin
      ready = '0;
      a_hit = 1'b0;
      b_hit = 1'b0;
      a_idx = '0;
      b_idx = '0;
      pos   = '0;
      idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         pos = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (pos >= (IDX_W+1)'(N_REQ)) pos = pos - (IDX_W+1)'(N_REQ);
         idx = pos[IDX_W-1:0];
         if (bus.req_valid[idx]) begin
            if (addr_arr[idx] == '0) begin
               ready[idx] = 1'b1;
            end else if (!a_hit) begin
               a_hit      = 1'b1;
               a_idx      = idx;
               ready[idx] = 1'b1;
            end else if (!b_hit && (addr_arr[idx] != addr_arr[a_idx])) begin
               b_hit      = 1'b1;
               b_idx      = idx;
               ready[idx] = 1'b1;
            end
         end
      end
   end

   assign grant         = rst ? '0 : ready;
   assign bus.req_ready = grant;

`ifdef WB_ARB_FIXED_PRIO_EN
   assign rr_ptr = '0;
`else
   idx_t rr_ptr_q, rr_ptr_d;

   function automatic idx_t wrap_inc(input idx_t i);
      return (i == idx_t'(N_REQ-1)) ? '0 : i + idx_t'(1);
   endfunction

   // Pointer moves just past the last port winner so that winner drops to lowest priority.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (b_hit)      rr_ptr_d = wrap_inc(b_idx);
      else if (a_hit) rr_ptr_d = wrap_inc(a_idx);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rr_ptr_q <= '0;
      else     rr_ptr_q <= rr_ptr_d;
   end

   assign rr_ptr = rr_ptr_q;
`endif

   always_comb begin
      we_a_d      = a_hit;
      we_b_d      = b_hit;
      waddr_a_d   = a_hit ? addr_arr[a_idx] : waddr_a_q;
      wdata_a_d   = a_hit ? data_arr[a_idx] : wdata_a_q;
      waddr_b_d   = b_hit ? addr_arr[b_idx] : waddr_b_q;
      wdata_b_d   = b_hit ? data_arr[b_idx] : wdata_b_q;
      stall_cnt_d = stall_cnt_q;
      if (|(bus.req_valid & ~grant) && (stall_cnt_q != 16'hFFFF))
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_a_q      <= 1'b0;
         we_b_q      <= 1'b0;
         waddr_a_q   <= '0;
         waddr_b_q   <= '0;
         wdata_a_q   <= '0;
         wdata_b_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         we_a_q      <= we_a_d;
         we_b_q      <= we_b_d;
         waddr_a_q   <= waddr_a_d;
         waddr_b_q   <= waddr_b_d;
         wdata_a_q   <= wdata_a_d;
         wdata_b_q   <= wdata_b_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.we_a      = we_a_q;
   assign bus.we_b      = we_b_q;
   assign bus.waddr_a   = waddr_a_q;
   assign bus.waddr_b   = waddr_b_q;
   assign bus.wdata_a   = wdata_a_q;
   assign bus.wdata_b   = wdata_b_q;
   assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_wb_arbiter;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int N  = 4;
   localparam int OW = 2 + 2*AW + 2*DW + 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_REQ(N)) bus ();
   wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [N-1:0]  drv_valid;
   logic [AW-1:0] drv_addr [N];
   logic [DW-1:0] drv_data [N];

   always_comb begin
      bus.req_valid = drv_valid;
      bus.req_addr  = '0;
      bus.req_data  = '0;
      for (int i = 0; i < N; i++) begin
         bus.req_addr[i*AW +: AW] = drv_addr[i];
         bus.req_data[i*DW +: DW] = drv_data[i];
      end
   end

   int passed = 0;
   int total  = 0;

   // Reference model state
   int            m_rr, m_stall;
   logic          m_we_a, m_we_b;
   logic [AW-1:0] m_waddr_a, m_waddr_b;
   logic [DW-1:0] m_wdata_a, m_wdata_b;
   int            nx_rr, nx_stall;
   logic          nx_we_a, nx_we_b;
   logic [AW-1:0] nx_waddr_a, nx_waddr_b;
   logic [DW-1:0] nx_wdata_a, nx_wdata_b;
   logic [N-1:0]  exp_ready, acc;
   logic [OW-1:0] got_o, exp_o;

   task automatic model_eval();
      int cand[$];
      int a, b, idx;
      exp_ready  = '0;
      nx_we_a    = 1'b0;
      nx_we_b    = 1'b0;
      nx_waddr_a = m_waddr_a;
      nx_waddr_b = m_waddr_b;
      nx_wdata_a = m_wdata_a;
      nx_wdata_b = m_wdata_b;
      nx_rr      = m_rr;
      nx_stall   = m_stall;
      if (rst) begin
         nx_waddr_a = '0; nx_waddr_b = '0;
         nx_wdata_a = '0; nx_wdata_b = '0;
         nx_rr = 0; nx_stall = 0;
      end else begin
         a = -1;
         b = -1;
         for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (drv_valid[idx]) begin
               if (drv_addr[idx] == 0) exp_ready[idx] = 1'b1;
               else cand.push_back(idx);
            end
         end
         if (cand.size() > 0) a = cand[0];
         foreach (cand[j])
            if (j > 0 && b < 0 && drv_addr[cand[j]] != drv_addr[a]) b = cand[j];
         if (a >= 0) begin
            exp_ready[a] = 1'b1;
            nx_we_a = 1'b1; nx_waddr_a = drv_addr[a]; nx_wdata_a = drv_data[a];
            nx_rr = (a + 1) % N;
         end
         if (b >= 0) begin
            exp_ready[b] = 1'b1;
            nx_we_b = 1'b1; nx_waddr_b = drv_addr[b]; nx_wdata_b = drv_data[b];
            nx_rr = (b + 1) % N;
         end
`ifdef WB_ARB_FIXED_PRIO_EN
         nx_rr = 0;
`endif
         if ((drv_valid & ~exp_ready) != '0 && nx_stall < 65535) nx_stall = nx_stall + 1;
      end
      acc = drv_valid & exp_ready;
   endtask

   task automatic settle();
      #1;
      model_eval();
   endtask

   task automatic advance();
      @(posedge clk);
      m_rr = nx_rr; m_stall = nx_stall;
      m_we_a = nx_we_a; m_we_b = nx_we_b;
      m_waddr_a = nx_waddr_a; m_waddr_b = nx_waddr_b;
      m_wdata_a = nx_wdata_a; m_wdata_b = nx_wdata_b;
      @(negedge clk);
   endtask

   // Lone grant to requester 3 leaves the rotation pointer at 0.
   task automatic align();
      drv_valid = 4'b1000; drv_addr[3] = 5'd1; drv_data[3] = $urandom;
      settle(); advance();
      drv_valid = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drv_valid = '1;
      for (int i = 0; i < N; i++) begin
         drv_addr[i] = AW'(i + 1);
         drv_data[i] = $urandom;
      end
      repeat (2) begin settle(); advance(); end
      settle();
      total++;
      if (bus.req_ready !== '0) $display("FAIL reset_ready: got %b want 0000", bus.req_ready);
      else passed++;
      got_o = {bus.we_a, bus.waddr_a, bus.wdata_a, bus.we_b, bus.waddr_b, bus.wdata_b, bus.stall_cnt};
      total++;
      if (got_o !== '0) $display("FAIL reset_outputs: got %h want 0", got_o);
      else passed++;
      rst = 1'b0;
      settle();
      total++;
      if (bus.req_ready !== 4'b0011) $display("FAIL release_ready: got %b want 0011", bus.req_ready);
      else passed++;
      advance();
      total++;
      if ({bus.we_a, bus.waddr_a, bus.wdata_a, bus.we_b, bus.waddr_b, bus.wdata_b, bus.stall_cnt} !==
          {1'b1, 5'd1, drv_data[0], 1'b1, 5'd2, drv_data[1], 16'd1})
         $display("FAIL release_grant: got a=%0d/%0d b=%0d/%0d stall=%0d want a=1/1 b=1/2 stall=1",
                  bus.we_a, bus.waddr_a, bus.we_b, bus.waddr_b, bus.stall_cnt);
      else passed++;
      drv_valid = '0;
   endtask

   task automatic test_dual_issue();
      int s0;
      align();
      drv_valid = 4'b0101;
      drv_addr[0] = 5'd3; drv_data[0] = 32'h11;
      drv_addr[2] = 5'd7; drv_data[2] = 32'h22;
      settle();
      total++;
      if (bus.req_ready !== 4'b0101) $display("FAIL dual_ready: got %b want 0101", bus.req_ready);
      else passed++;
      advance();
      total++;
      if ({bus.we_a, bus.waddr_a, bus.wdata_a, bus.we_b, bus.waddr_b, bus.wdata_b} !==
          {1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22})
         $display("FAIL dual_ports: got a=%0d/%0d/%h b=%0d/%0d/%h want a=1/3/11 b=1/7/22",
                  bus.we_a, bus.waddr_a, bus.wdata_a, bus.we_b, bus.waddr_b, bus.wdata_b);
      else passed++;
      drv_valid = '0;
      s0 = m_stall;
      settle(); advance();
      total++;
      if ({bus.we_a, bus.we_b, bus.stall_cnt} !== {2'b00, 16'(s0)})
         $display("FAIL idle_cycle: got we=%b%b stall=%0d want we=00 stall=%0d",
                  bus.we_a, bus.we_b, bus.stall_cnt, s0);
      else passed++;
   endtask

   task automatic test_conflict();
      int s0;
      align();
      drv_valid = 4'b1011;
      drv_addr[0] = 5'd5; drv_data[0] = 32'hA0;
      drv_addr[1] = 5'd5; drv_data[1] = 32'hA1;
      drv_addr[3] = 5'd9; drv_data[3] = 32'hA3;
      s0 = m_stall;
      settle();
      total++;
      if (bus.req_ready !== 4'b1001) $display("FAIL conflict_ready: got %b want 1001", bus.req_ready);
      else passed++;
      advance();
      total++;
      if ({bus.we_a, bus.waddr_a, bus.wdata_a, bus.we_b, bus.waddr_b, bus.wdata_b, bus.stall_cnt} !==
          {1'b1, 5'd5, 32'hA0, 1'b1, 5'd9, 32'hA3, 16'(s0 + 1)})
         $display("FAIL conflict_ports: got a=%0d/%0d/%h b=%0d/%0d/%h stall=%0d want a=1/5/a0 b=1/9/a3 stall=%0d",
                  bus.we_a, bus.waddr_a, bus.wdata_a, bus.we_b, bus.waddr_b, bus.wdata_b, bus.stall_cnt, s0 + 1);
      else passed++;
      drv_valid = 4'b0010;
      settle();
      total++;
      if (bus.req_ready !== 4'b0010) $display("FAIL conflict_retry_ready: got %b want 0010", bus.req_ready);
      else passed++;
      advance();
      total++;
      if ({bus.we_a, bus.waddr_a, bus.wdata_a, bus.we_b} !== {1'b1, 5'd5, 32'hA1, 1'b0})
         $display("FAIL conflict_retry: got a=%0d/%0d/%h we_b=%0d want a=1/5/a1 we_b=0",
                  bus.we_a, bus.waddr_a, bus.wdata_a, bus.we_b);
      else passed++;
      drv_valid = '0;
   endtask

   task automatic test_addr_zero();
      int s0;
      align();
      drv_valid = 4'b0010; drv_addr[1] = 5'd0; drv_data[1] = 32'hDEAD;
      s0 = m_stall;
      settle();
      total++;
      if (bus.req_ready !== 4'b0010) $display("FAIL zero_ready: got %b want 0010", bus.req_ready);
      else passed++;
      advance();
      total++;
      if ({bus.we_a, bus.we_b, bus.stall_cnt} !== {2'b00, 16'(s0)})
         $display("FAIL zero_no_write: got we=%b%b stall=%0d want we=00 stall=%0d",
                  bus.we_a, bus.we_b, bus.stall_cnt, s0);
      else passed++;
      // Pointer must still be 0: requester 0 takes port A ahead of requester 2.
      drv_valid = 4'b0101;
      drv_addr[0] = 5'd4; drv_data[0] = 32'hB0;
      drv_addr[2] = 5'd6; drv_data[2] = 32'hB2;
      settle(); advance();
      total++;
      if ({bus.waddr_a, bus.waddr_b} !== {5'd4, 5'd6})
         $display("FAIL zero_ptr_hold: got waddr_a=%0d waddr_b=%0d want 4 6", bus.waddr_a, bus.waddr_b);
      else passed++;
      drv_valid = '0;
   endtask

   task automatic test_fairness();
      int cnt [N];
      int ea, eb;
      logic [N-1:0]  emask;
      logic [DW-1:0] da, db;
      align();
      foreach (cnt[i]) cnt[i] = 0;
      drv_valid = '1;
      for (int i = 0; i < N; i++) begin
         drv_addr[i] = AW'(i + 1);
         drv_data[i] = $urandom;
      end
      for (int c = 0; c < 4; c++) begin
`ifdef WB_ARB_FIXED_PRIO_EN
         ea = 0; eb = 1;
`else
         ea = (c % 2 == 0) ? 0 : 2;
         eb = ea + 1;
`endif
         emask = '0; emask[ea] = 1'b1; emask[eb] = 1'b1;
         da = drv_data[ea]; db = drv_data[eb];
         settle();
         total++;
         if (bus.req_ready !== emask) $display("FAIL fair_ready_c%0d: got %b want %b", c, bus.req_ready, emask);
         else passed++;
         for (int i = 0; i < N; i++) if (bus.req_ready[i]) cnt[i]++;
         advance();
         total++;
         if ({bus.we_a, bus.waddr_a, bus.wdata_a, bus.we_b, bus.waddr_b, bus.wdata_b} !==
             {1'b1, AW'(ea + 1), da, 1'b1, AW'(eb + 1), db})
            $display("FAIL fair_ports_c%0d: got a=%0d/%h b=%0d/%h want a=%0d/%h b=%0d/%h",
                     c, bus.waddr_a, bus.wdata_a, bus.waddr_b, bus.wdata_b, ea + 1, da, eb + 1, db);
         else passed++;
         for (int i = 0; i < N; i++) if (acc[i]) drv_data[i] = $urandom;
      end
      total++;
`ifdef WB_ARB_FIXED_PRIO_EN
      if (cnt[0] != 4 || cnt[1] != 4 || cnt[2] != 0 || cnt[3] != 0)
         $display("FAIL fair_counts: got %0d %0d %0d %0d want 4 4 0 0", cnt[0], cnt[1], cnt[2], cnt[3]);
`else
      if (cnt[0] != 2 || cnt[1] != 2 || cnt[2] != 2 || cnt[3] != 2)
         $display("FAIL fair_counts: got %0d %0d %0d %0d want 2 2 2 2", cnt[0], cnt[1], cnt[2], cnt[3]);
`endif
      else passed++;
      drv_valid = '0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         if (c == 300) rst = 1'b1;
         if (c == 302) rst = 1'b0;
         settle();
         total++;
         if (bus.req_ready !== exp_ready)
            $display("FAIL rand_ready_c%0d: got %b want %b", c, bus.req_ready, exp_ready);
         else passed++;
         if (c == 300) begin
            got_o = {bus.we_a, bus.waddr_a, bus.wdata_a, bus.we_b, bus.waddr_b, bus.wdata_b, bus.stall_cnt};
            total++;
            if (got_o !== '0) $display("FAIL rand_async_reset: got %h want 0", got_o);
            else passed++;
         end
         advance();
         got_o = {bus.we_a, bus.waddr_a, bus.wdata_a, bus.we_b, bus.waddr_b, bus.wdata_b, bus.stall_cnt};
         exp_o = {m_we_a, m_waddr_a, m_wdata_a, m_we_b, m_waddr_b, m_wdata_b, 16'(m_stall)};
         total++;
         if (got_o !== exp_o) $display("FAIL rand_out_c%0d: got %h want %h", c, got_o, exp_o);
         else passed++;
         for (int i = 0; i < N; i++) begin
            if (acc[i] || !drv_valid[i]) begin
               drv_valid[i] = ($urandom_range(0, 9) < 7);
               drv_addr[i]  = AW'($urandom_range(0, 4));
               drv_data[i]  = $urandom;
            end
         end
      end
      drv_valid = '0;
   endtask

   task automatic test_saturation();
      int bad = 0;
      align();
      drv_valid = 4'b0011;
      drv_addr[0] = 5'd6; drv_addr[1] = 5'd6;
      for (int c = 0; c < 70000; c++) begin
         settle();
         if (bus.req_ready !== exp_ready) bad++;
         advance();
         if (bus.stall_cnt !== 16'(m_stall)) bad++;
         for (int i = 0; i < 2; i++) if (acc[i]) drv_data[i] = $urandom;
      end
      total++;
      if (bad != 0) $display("FAIL sat_tracking: got %0d cycle mismatches want 0", bad);
      else passed++;
      total++;
      if (bus.stall_cnt !== 16'hFFFF) $display("FAIL sat_value: got %h want ffff", bus.stall_cnt);
      else passed++;
      drv_valid = '0;
   endtask

   initial begin
      rst = 1'b1;
      drv_valid = '0;
      for (int i = 0; i < N; i++) begin
         drv_addr[i] = '0;
         drv_data[i] = '0;
      end
      m_rr = 0; m_stall = 0; m_we_a = 1'b0; m_we_b = 1'b0;
      m_waddr_a = '0; m_waddr_b = '0; m_wdata_a = '0; m_wdata_b = '0;
      @(negedge clk);
      test_reset();
      test_dual_issue();
      test_conflict();
      test_addr_zero();
      test_fairness();
      test_random();
      test_saturation();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter for the dual-write-port register file. It accepts register-write requests from N_REQ execution units over valid/ready handshakes and grants at most two per cycle. It drives the RF's A and B write ports from registered outputs. Same-address pairs are never issued in one cycle, so the RF's "B wins" collision rule is never exercised. A saturating stall counter supports performance debug.

## Interface
- ADDR_WIDTH, 5, register address width
- DATA_WIDTH, 32, register data width
- N_REQ, 4, number of requesters (2..8)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  request valid, one bit per requester
- req_addr  in  N_REQ*ADDR_WIDTH  destination register; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  in  N_REQ*DATA_WIDTH  write data, packed the same way
- req_ready  out  N_REQ  grant; transfer occurs when req_valid[i] & req_ready[i] are high at a clk edge
- we_a, we_b  out  1  RF write enables (registered)
- waddr_a, waddr_b  out  ADDR_WIDTH  RF write addresses (registered)
- wdata_a, wdata_b  out  DATA_WIDTH  RF write data (registered)
- stall_cnt  out  16  saturating count of cycles in which at least one valid request was not granted

## Operation
- Candidate scan:
  - Requesters are scanned in rotated order rr_ptr, rr_ptr+1, …, wrapping modulo N_REQ.
  - With WB_ARB_FIXED_PRIO_EN, the scan always starts at index 0.
- Address-0 requests:
  - req_valid[i] with address 0 gets req_ready[i]=1 immediately.
  - It consumes no port and produces no write enable (the write is discarded).
- First grant: the first valid requester in scan order with a nonzero address gets port A.
- Second grant: the next valid requester in scan order with a nonzero address, where that address differs from the port-A address, gets port B.
- Same-address requester: a requester whose address equals the port-A address is skipped this cycle. The scan continues past it.
- req_ready is combinational from req_valid, req_addr and rr_ptr. It does not depend on the requester having seen ready first.
- Requesters must hold valid, addr and data stable until accepted.
- On each clk edge:
  - we_a <= (port A granted); waddr_a/wdata_a <= the port-A requester's fields when granted, otherwise hold.
  - Port B follows the same rule.
- rr_ptr update, on any nonzero-address grant: rr_ptr <= (index of last granted requester + 1) mod N_REQ. Otherwise rr_ptr holds.
- stall_cnt increments when any req_valid bit has req_ready=0, and saturates at 16'hFFFF.

## Timing
- Latency: accepted at edge k; RF write enables asserted in cycle k+1; RF array updated at edge k+1.
- Throughput: 2 writes per cycle when two distinct nonzero addresses are pending.
- Reset values, while rst is high:
  - we_a=0, we_b=0, waddr_a=0, waddr_b=0, wdata_a=0, wdata_b=0
  - rr_ptr=0, stall_cnt=0
  - req_ready forced to all-zero (no address-0 acceptance either).
- Reset asserted mid-transfer: a transfer at the same edge as reset is lost. Requesters must re-present after reset.
- All requesters valid with the same address: one grant per cycle, rotating. No starvation, because rr_ptr passes the winner.
- Single valid requester: port A only, we_b=0.
- No valid requesters: we_a=we_b=0 next cycle; rr_ptr and stall_cnt hold.

## Configuration
- WB_ARB_FIXED_PRIO_EN defined:
  - Fixed priority; requester 0 is highest.
  - rr_ptr is removed (reads as 0).
  - Low-index requesters may starve high-index ones.
- Undefined (default): round-robin as above.

## Test plan
- Reset: assert rst with all req_valid=1 -> req_ready=0, we_a=we_b=0, stall_cnt=0. Release rst -> grants start on the next edge.
- Dual issue: req0 (addr 3, 32'h11), req2 (addr 7, 32'h22) valid -> req_ready=4'b0101. Next cycle: we_a=1, waddr_a=3, wdata_a=32'h11; we_b=1, waddr_b=7, wdata_b=32'h22. rr_ptr=3.
- Address conflict: req0 and req1 both target addr 5, req3 targets addr 9, rr_ptr=0 -> grants req0 (A) and req3 (B); req1 stalled; stall_cnt +1. The following cycle grants req1 on port A.
- Address zero: only req1 valid with addr 0 -> req_ready=4'b0010, we_a=we_b=0 next cycle, rr_ptr unchanged.
- Fairness: all four valid with distinct addresses, held for 4 cycles -> each requester granted exactly twice, order (0,1),(2,3),(0,1),(2,3) after re-presenting.
- Saturation: hold one requester blocked for 70000 cycles -> stall_cnt stays at 16'hFFFF.
